spi_bus_arbiter: RTL and testbench

- Generalised successor to the fixed 1-bit select muxes that share the SD-card SPI bus between the autotest engine and a single UUT.
- Arbitrates N_MASTERS SPI masters onto one physical bus (cs/sclk/mosi out, miso in) via a req/grant handshake.
- Switches ownership only after the bus is proven idle for a guard interval. Two selectable priority modes and a hold-timeout watchdog.
- Sits between the autotest/UUT masters and the SD pads in the performance-test top level.

---
 rtl/spi_arb_pkg.sv | 20 ++
 rtl/spi_bus_arbiter_rr.sv | 41 ++++
 rtl/spi_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANTED = 2'd1,
      RELEASE = 2'd2,
      GUARD   = 2'd3
   } state_t;

   localparam logic CS_IDLE   = 1'b1;
   localparam logic SCLK_IDLE = 1'b0;
   localparam logic MOSI_IDLE = 1'b1;

   // Width of a counter that must hold values 0..n (never less than one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n == 0) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr.sv
// Combinational winner pick: round-robin from ptr, or fixed lowest-index priority.
module rr_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned N_MASTERS = 2,
   parameter int unsigned OWNER_W   = 1,
   parameter int unsigned RR_MODE   = 1
) (
   input  logic [N_MASTERS-1:0] req,
   input  logic [OWNER_W-1:0]   ptr,
   output logic                 valid,
   output logic [OWNER_W-1:0]   idx
);

   localparam int unsigned SUM_W = OWNER_W + 1;

   logic [OWNER_W-1:0]     base;
   logic [2*N_MASTERS-1:0] req2;
   logic [N_MASTERS-1:0]   rot;
   logic [SUM_W-1:0]       sum;

   // Rotate requests so the search origin sits at bit 0, then take the lowest set bit.
   always_comb begin
      base  = (RR_MODE != 0) ? ptr : '0;
      req2  = {req, req};
      rot   = N_MASTERS'(req2 >> base);
      valid = 1'b0;
      sum   = '0;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         if (rot[i]) begin
            valid = 1'b1;
            sum   = SUM_W'(base) + SUM_W'(i);
         end
      end
      if (sum >= SUM_W'(N_MASTERS)) begin
         sum = sum - SUM_W'(N_MASTERS);
      end
      idx = OWNER_W'(sum);
   end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus among N masters via req/grant, with a forced-idle guard
// between owners and a hold-timeout watchdog.
module spi_bus_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned N_MASTERS      = 2,
   parameter int unsigned GUARD_CYCLES   = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1048576,
   parameter int unsigned RR_MODE        = 1,
   parameter int unsigned OWNER_W        = $clog2(N_MASTERS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MASTERS-1:0] req,
   output logic [N_MASTERS-1:0] grant,
   input  logic [N_MASTERS-1:0] cs_i,
   input  logic [N_MASTERS-1:0] sclk_i,
   input  logic [N_MASTERS-1:0] mosi_i,
   output logic [N_MASTERS-1:0] miso_o,
   output logic                 cs,
   output logic                 sclk,
   output logic                 mosi,
   input  logic                 miso,
   output logic [OWNER_W-1:0]   owner,
   output logic                 bus_busy,
   output logic                 timeout_err
);

   localparam int unsigned TO_W = cnt_w(TIMEOUT_CYCLES);
   localparam int unsigned GD_W = cnt_w(GUARD_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST =
      TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [GD_W-1:0] GD_LAST = GD_W'(GUARD_CYCLES - 1);

   state_t               state_q, state_d;
   logic [N_MASTERS-1:0] grant_q, grant_d;
   logic [OWNER_W-1:0]   owner_q, owner_d;
   logic [OWNER_W-1:0]   ptr_q, ptr_d;
   logic [GD_W-1:0]      gcnt_q, gcnt_d;
   logic [TO_W-1:0]      tcnt_q, tcnt_d;
   logic                 busy_q, busy_d;
   logic                 terr_q, terr_d;

   logic                 arb_valid;
   logic [OWNER_W-1:0]   arb_idx;
   logic [OWNER_W-1:0]   nxt_ptr;
   logic                 other_req;
   logic                 to_fire;
   logic                 drive;

   rr_arbiter #(
      .N_MASTERS (N_MASTERS),
      .OWNER_W   (OWNER_W),
      .RR_MODE   (RR_MODE)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (arb_valid),
      .idx   (arb_idx)
   );

   // Next-state, counters and registered outputs.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      gcnt_d    = gcnt_q;
      tcnt_d    = tcnt_q;
      terr_d    = 1'b0;
      to_fire   = 1'b0;
      nxt_ptr   = (arb_idx == OWNER_W'(N_MASTERS - 1)) ? '0 : arb_idx + OWNER_W'(1);
      other_req = |(req & ~grant_q);

      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               state_d = GRANTED;
               grant_d = N_MASTERS'(1) << arb_idx;
               owner_d = arb_idx;
               ptr_d   = nxt_ptr;
               tcnt_d  = '0;
            end
         end
         GRANTED: begin
            // Watchdog only runs while someone else is waiting; it wins over a release.
            if ((TIMEOUT_CYCLES != 0) && other_req) begin
               if (tcnt_q == TO_LAST) begin
                  to_fire = 1'b1;
               end else begin
                  tcnt_d = tcnt_q + TO_W'(1);
               end
            end else begin
               tcnt_d = '0;
            end
            if (to_fire) begin
               state_d = GUARD;
               grant_d = '0;
               terr_d  = 1'b1;
               gcnt_d  = '0;
               tcnt_d  = '0;
            end else if (!req[owner_q]) begin
               state_d = RELEASE;
               grant_d = '0;
               tcnt_d  = '0;
            end
         end
         RELEASE: begin
            if (cs_i[owner_q]) begin
               state_d = GUARD;
               gcnt_d  = '0;
            end
         end
         GUARD: begin
            if (gcnt_q == GD_LAST) begin
               gcnt_d = '0;
               if (arb_valid) begin
                  state_d = GRANTED;
                  grant_d = N_MASTERS'(1) << arb_idx;
                  owner_d = arb_idx;
                  ptr_d   = nxt_ptr;
                  tcnt_d  = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gcnt_d = gcnt_q + GD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase

      busy_d = (state_d == GRANTED) || (state_d == RELEASE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         gcnt_q  <= '0;
         tcnt_q  <= '0;
         busy_q  <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         gcnt_q  <= gcnt_d;
         tcnt_q  <= tcnt_d;
         busy_q  <= busy_d;
         terr_q  <= terr_d;
      end
   end

   // Bus mux is a pure pass-through of the owner so SCLK and MISO keep their phase.
   always_comb begin
      drive  = (state_q == GRANTED) || (state_q == RELEASE);
      cs     = drive ? cs_i[owner_q]   : CS_IDLE;
      sclk   = drive ? sclk_i[owner_q] : SCLK_IDLE;
      mosi   = drive ? mosi_i[owner_q] : MOSI_IDLE;
      miso_o = '1;
      if (drive) begin
         miso_o[owner_q] = miso;
      end
   end

   assign grant       = grant_q;
   assign owner       = owner_q;
   assign bus_busy    = busy_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Checks a round-robin and a fixed-priority arbiter (4 masters) against a
// behavioural model, plus literal expectations for the key scenarios.
module tb_spi_bus_arbiter;

   localparam int NM = 4;
   localparam int GC = 8;
   localparam int TC = 16;
   localparam int P_IDLE = 0, P_GRANTED = 1, P_RELEASE = 2, P_GUARD = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [NM-1:0] req, cs_i, sclk_i, mosi_i;
   logic          miso;

   logic [NM-1:0] grant_w [2];
   logic [NM-1:0] miso_w  [2];
   logic [1:0]    owner_w [2];
   logic          busy_w  [2];
   logic          terr_w  [2];
   logic          cs_w    [2];
   logic          sclk_w  [2];
   logic          mosi_w  [2];

   int total = 0;
   int bad   = 0;

   // Model state per instance (0 = round-robin, 1 = fixed priority).
   int ph [2], own [2], ptr [2], gel [2], wt [2];
   bit ter [2];

   always #5 clk = ~clk;

   spi_bus_arbiter #(.N_MASTERS(NM), .GUARD_CYCLES(GC), .TIMEOUT_CYCLES(TC), .RR_MODE(1)) u_rr (
      .clk(clk), .rst(rst), .req(req), .grant(grant_w[0]), .cs_i(cs_i), .sclk_i(sclk_i),
      .mosi_i(mosi_i), .miso_o(miso_w[0]), .cs(cs_w[0]), .sclk(sclk_w[0]), .mosi(mosi_w[0]),
      .miso(miso), .owner(owner_w[0]), .bus_busy(busy_w[0]), .timeout_err(terr_w[0]));

   spi_bus_arbiter #(.N_MASTERS(NM), .GUARD_CYCLES(GC), .TIMEOUT_CYCLES(TC), .RR_MODE(0)) u_fix (
      .clk(clk), .rst(rst), .req(req), .grant(grant_w[1]), .cs_i(cs_i), .sclk_i(sclk_i),
      .mosi_i(mosi_i), .miso_o(miso_w[1]), .cs(cs_w[1]), .sclk(sclk_w[1]), .mosi(mosi_w[1]),
      .miso(miso), .owner(owner_w[1]), .bus_busy(busy_w[1]), .timeout_err(terr_w[1]));

   task automatic cmp(input string nm, input int m, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s inst%0d got=%0h expected=%0h at %0t", nm, m, got, exp, $time);
      end
   endtask

   function automatic int pick(input int m);
      int i;
      for (int k = 0; k < NM; k++) begin
         i = (m == 0) ? (ptr[m] + k) % NM : k;
         if (req[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         ph[m] = P_IDLE; own[m] = 0; ptr[m] = 0; gel[m] = 0; wt[m] = 0; ter[m] = 1'b0;
      end
   endtask

   task automatic give(input int m, input int w);
      ph[m] = P_GRANTED; own[m] = w; ptr[m] = (w + 1) % NM; wt[m] = 0;
   endtask

   // One clock of the specification's rules, using the inputs present at the edge.
   task automatic model_step();
      int w;
      bit others;
      for (int m = 0; m < 2; m++) begin
         ter[m] = 1'b0;
         case (ph[m])
            P_IDLE: begin
               w = pick(m);
               if (w >= 0) give(m, w);
            end
            P_GRANTED: begin
               others = 1'b0;
               for (int i = 0; i < NM; i++) if (i != own[m] && req[i]) others = 1'b1;
               if (others) begin
                  wt[m]++;
                  if (wt[m] == TC) begin
                     ph[m] = P_GUARD; gel[m] = 0; ter[m] = 1'b1; wt[m] = 0;
                  end
               end else begin
                  wt[m] = 0;
               end
               if (ph[m] == P_GRANTED && !req[own[m]]) ph[m] = P_RELEASE;
            end
            P_RELEASE: begin
               if (cs_i[own[m]]) begin
                  ph[m] = P_GUARD; gel[m] = 0;
               end
            end
            default: begin
               gel[m]++;
               if (gel[m] == GC) begin
                  w = pick(m);
                  if (w >= 0) give(m, w);
                  else ph[m] = P_IDLE;
               end
            end
         endcase
      end
   endtask

   task automatic check_all();
      bit drive;
      logic [NM-1:0] eg, em;
      for (int m = 0; m < 2; m++) begin
         drive = (ph[m] == P_GRANTED) || (ph[m] == P_RELEASE);
         eg = '0;
         if (ph[m] == P_GRANTED) eg[own[m]] = 1'b1;
         em = '1;
         if (drive) em[own[m]] = miso;
         cmp("grant", m, 32'(grant_w[m]), 32'(eg));
         cmp("owner", m, 32'(owner_w[m]), 32'(own[m]));
         cmp("bus_busy", m, 32'(busy_w[m]), 32'(drive));
         cmp("timeout_err", m, 32'(terr_w[m]), 32'(ter[m]));
         cmp("cs", m, 32'(cs_w[m]), drive ? 32'(cs_i[own[m]]) : 32'd1);
         cmp("sclk", m, 32'(sclk_w[m]), drive ? 32'(sclk_i[own[m]]) : 32'd0);
         cmp("mosi", m, 32'(mosi_w[m]), drive ? 32'(mosi_i[own[m]]) : 32'd1);
         cmp("miso_o", m, 32'(miso_w[m]), 32'(em));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic rand_bus();
      cs_i   = NM'($urandom_range(0, 15));
      sclk_i = NM'($urandom());
      mosi_i = NM'($urandom());
      miso   = 1'($urandom());
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int n_on [2];
      int hold [2];
      bit hold_done [2];
      logic [NM-1:0] prev [2];
      logic [NM-1:0] on_v [2][5];
      logic [NM-1:0] exp_rr [5];
      int gz;
      bit got;

      exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
      exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;

      // Reset with every master requesting: bus must stay forced idle.
      req = 4'b1111; cs_i = 4'b0000; sclk_i = 4'b1111; mosi_i = 4'b0000; miso = 1'b0;
      model_reset();
      tick();
      tick();
      for (int m = 0; m < 2; m++) begin
         cmp("rst_grant", m, 32'(grant_w[m]), 32'h0);
         cmp("rst_cs", m, 32'(cs_w[m]), 32'h1);
         cmp("rst_sclk", m, 32'(sclk_w[m]), 32'h0);
         cmp("rst_mosi", m, 32'(mosi_w[m]), 32'h1);
         cmp("rst_miso_o", m, 32'(miso_w[m]), 32'hf);
      end
      rst = 1'b1;
      tick();
      for (int m = 0; m < 2; m++) begin
         cmp("first_grant", m, 32'(grant_w[m]), 32'h1);
         cmp("first_owner", m, 32'(owner_w[m]), 32'h0);
      end

      // All masters hold req: watchdog rotates RR owners, fixed mode keeps master 0.
      for (int m = 0; m < 2; m++) begin
         n_on[m] = 1; on_v[m][0] = grant_w[m]; prev[m] = grant_w[m];
         hold[m] = 1; hold_done[m] = 1'b0;
      end
      for (int c = 0; c < 200 && (n_on[0] < 5 || n_on[1] < 5); c++) begin
         rand_bus();
         tick();
         for (int m = 0; m < 2; m++) begin
            if (grant_w[m] != 0 && prev[m] == 0 && n_on[m] < 5) begin
               on_v[m][n_on[m]] = grant_w[m];
               n_on[m]++;
            end
            if (!hold_done[m]) begin
               if (grant_w[m] == 4'b0001) hold[m]++;
               else begin
                  hold_done[m] = 1'b1;
                  cmp("hold_len", m, 32'(hold[m]), 32'd16);
                  cmp("first_terr", m, 32'(terr_w[m]), 32'd1);
               end
            end
            prev[m] = grant_w[m];
         end
      end
      for (int m = 0; m < 2; m++) begin
         cmp("grant_count", m, 32'(n_on[m]), 32'd5);
         for (int k = 0; k < 5; k++)
            cmp("grant_order", m, 32'(on_v[m][k]), (m == 0) ? 32'(exp_rr[k]) : 32'h1);
      end

      // Asynchronous reset while GRANTED, between clock edges.
      for (int c = 0; c < 50 && !(ph[0] == P_GRANTED && ph[1] == P_GRANTED); c++) tick();
      cmp("reach_granted", 0, 32'(ph[0] == P_GRANTED && ph[1] == P_GRANTED), 32'd1);
      cs_i = 4'b0000; sclk_i = 4'b1111; mosi_i = 4'b0000;
      #1;
      cmp("pre_rst_cs", 0, 32'(cs_w[0]), 32'h0);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      for (int m = 0; m < 2; m++) begin
         cmp("arst_grant", m, 32'(grant_w[m]), 32'h0);
         cmp("arst_cs", m, 32'(cs_w[m]), 32'h1);
         cmp("arst_sclk", m, 32'(sclk_w[m]), 32'h0);
         cmp("arst_mosi", m, 32'(mosi_w[m]), 32'h1);
      end
      req = 4'b0000;
      tick();
      rst = 1'b1;
      tick();

      // Master 0 frame, release with cs low, then guard; req[1] arrives mid-guard.
      req = 4'b0001; cs_i = 4'b0000; sclk_i = 4'b0000; mosi_i = 4'b0000; miso = 1'b0;
      tick();
      for (int m = 0; m < 2; m++) cmp("m0_grant", m, 32'(grant_w[m]), 32'h1);
      sclk_i = 4'b0001;
      #1;
      for (int m = 0; m < 2; m++) begin
         cmp("m0_sclk", m, 32'(sclk_w[m]), 32'h1);
         cmp("m0_miso_o", m, 32'(miso_w[m]), 32'he);
      end
      req = 4'b0000;
      tick();
      for (int m = 0; m < 2; m++) begin
         cmp("rel_grant", m, 32'(grant_w[m]), 32'h0);
         cmp("rel_busy", m, 32'(busy_w[m]), 32'h1);
         cmp("rel_cs", m, 32'(cs_w[m]), 32'h0);
      end
      cs_i = 4'b0001;
      gz = 0; got = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (gz == 3) req = 4'b0010;
         tick();
         if (grant_w[0] != 0) begin
            got = 1'b1;
            break;
         end
         gz++;
      end
      cmp("guard_seen", 0, 32'(got), 32'd1);
      cmp("guard_len", 0, 32'(gz), 32'd8);
      for (int m = 0; m < 2; m++) cmp("guard_grant", m, 32'(grant_w[m]), 32'h2);

      // Randomised traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NM; i++)
            if ($urandom_range(0, 19) == 0) req[i] = ~req[i];
         cs_i   = 4'b0000;
         for (int i = 0; i < NM; i++) cs_i[i] = ($urandom_range(0, 2) == 0);
         sclk_i = NM'($urandom());
         mosi_i = NM'($urandom());
         miso   = 1'($urandom());
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
